// File: rtl/data_memory_bytelane_if.sv
// Request/response channel between the MEM stage and the byte-lane data memory.
//   req_valid/req_ready : request handshake (master -> slave)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request payload
//   rsp_valid/rsp_ready : response handshake (slave -> master, with backpressure)
//   rsp_rdata, rsp_err  : response payload
interface data_memory_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-addressable big-endian data memory for the MEM stage.
// Byte/half/word loads and stores, sign/zero extension, alignment and range
// checking, one outstanding request, response channel with backpressure.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low (memory contents are not reset)
//   bus  : slave side of data_memory_bytelane_if (request + response channels)
// READ_LATENCY of 1 responds to loads right after the accepting edge; any
// other value is treated as 2 and adds one output register stage.
module data_memory_bytelane #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_bytelane_if.slave  bus
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam bit          LAT_TWO = (READ_LATENCY != 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t       state;
  logic [7:0]   mem [DEPTH];

  logic         rsp_valid_q;
  logic [31:0]  rsp_rdata_q;
  logic         rsp_err_q;
  logic [31:0]  hold_rdata_q;
  logic         hold_err_q;

  logic              req_ready_c;
  logic              accept_c;
  logic              req_err_c;
  logic [ADDR_W-1:0] a0_c, a1_c, a2_c, a3_c;
  logic [7:0]        b0_c, b1_c, b2_c, b3_c;
  logic [31:0]       load_c;

  // Ready only when idle and out of reset, so a request at the reset edge is never accepted.
  assign req_ready_c   = (state == S_IDLE) && rst;
  assign accept_c      = bus.req_valid && req_ready_c;
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Lane addresses; mem[a0] is the most significant byte of the access.
  assign a0_c = bus.req_addr[ADDR_W-1:0];
  assign a1_c = a0_c + ADDR_W'(1);
  assign a2_c = a0_c + ADDR_W'(2);
  assign a3_c = a0_c + ADDR_W'(3);

  assign b0_c = mem[a0_c];
  assign b1_c = mem[a1_c];
  assign b2_c = mem[a2_c];
  assign b3_c = mem[a3_c];

  // Illegal size, misalignment, or any address bit above the decoded range.
  always_comb begin
    req_err_c = 1'b0;
    case (bus.req_size)
      SZ_BYTE: req_err_c = 1'b0;
      SZ_HALF: req_err_c = a0_c[0];
      SZ_WORD: req_err_c = (a0_c[1:0] != 2'b00);
      default: req_err_c = 1'b1;
    endcase
    if (bus.req_addr[31:ADDR_W] != '0) begin
      req_err_c = 1'b1;
    end
  end

  // Load data assembly with sign/zero extension; stores and errors return zero.
  always_comb begin
    load_c = '0;
    case (bus.req_size)
      SZ_BYTE: load_c = bus.req_unsigned ? {24'h0, b0_c} : {{24{b0_c[7]}}, b0_c};
      SZ_HALF: load_c = bus.req_unsigned ? {16'h0, b0_c, b1_c}
                                         : {{16{b0_c[7]}}, b0_c, b1_c};
      SZ_WORD: load_c = {b0_c, b1_c, b2_c, b3_c};
      default: load_c = '0;
    endcase
    if (req_err_c || bus.req_we) begin
      load_c = '0;
    end
  end

  // Store commit at the accepting edge; array has no reset.
  always_ff @(posedge clk) begin
    if (accept_c && bus.req_we && !req_err_c) begin
      case (bus.req_size)
        SZ_BYTE: begin
          mem[a0_c] <= bus.req_wdata[7:0];
        end
        SZ_HALF: begin
          mem[a0_c] <= bus.req_wdata[15:8];
          mem[a1_c] <= bus.req_wdata[7:0];
        end
        SZ_WORD: begin
          mem[a0_c] <= bus.req_wdata[31:24];
          mem[a1_c] <= bus.req_wdata[23:16];
          mem[a2_c] <= bus.req_wdata[15:8];
          mem[a3_c] <= bus.req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      hold_rdata_q <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            if (bus.req_we || !LAT_TWO) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_c;
              rsp_err_q   <= req_err_c;
            end else begin
              // Extra output stage: park the sampled load for one edge.
              state        <= S_WAIT;
              hold_rdata_q <= load_c;
              hold_err_q   <= req_err_c;
            end
          end
        end
        S_WAIT: begin
          state       <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= hold_rdata_q;
          rsp_err_q   <= hold_err_q;
        end
        S_RESP: begin
          // Outputs hold until the consumer takes the response.
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
